spi_master_arb: RTL and testbench
=================================

# spi_master_arb

SPI mode-0 master with a two-requester round-robin front end. Serialises one DATA_W-bit word per transaction onto sck/ss/mosi and captures miso. Returns the received word tagged with the requester id. Sits between on-chip clients (PS bridge, test pattern source) and the board-level SPI slave, which samples on sck rising edges with active-low ss.

## Interface
Parameters:
- DATA_W, 8, bits per transaction, MSB first; legal range 2..32.
- DIV, 4, sck half-period in clk cycles; minimum 1.

Ports:
- clk  in  1  system clock; one clock domain; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req0_valid  in  1  requester 0 has a word; held until accepted.
- req0_data  in  DATA_W  word to send for requester 0; stable while valid.
- req0_ready  out  1  accept strobe for requester 0 (combinational).
- req1_valid / req1_data / req1_ready: same for requester 1.
- rsp_valid  out  1  one-cycle pulse; received word available.
- rsp_data  out  DATA_W  word shifted in from miso.
- rsp_id  out  1  requester that owned the transaction.
- busy  out  1  high from the cycle after accept until the cycle before return to IDLE.
- sck  out  1  SPI clock, idle low (CPOL=0).
- ss  out  1  slave select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in; synchronous to sck, no extra synchroniser.

## Operation
- Reset values: sck=0, ss=1, mosi=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, state=IDLE, last_grant=1.
- Arbitration applies only in IDLE.
  - Exactly one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready = IDLE & grant==N. A handshake is valid&ready in the same cycle.
  - On handshake: latch data into the shift register, latch the id, set last_grant.
- States:
  - IDLE.
  - SETUP: ss=0, mosi=data[MSB], sck=0.
  - HIGH: sck=1.
  - LOW: sck=0.
  - HOLD: ss=0, sck=0, after the last bit.
  - GAP: ss=1.
- Each non-IDLE state lasts exactly DIV cycles, timed by a down-counter.
- Transitions:
  - IDLE→SETUP on handshake.
  - SETUP→HIGH.
  - HIGH→LOW.
  - LOW→HIGH while bits remain; LOW→HOLD after bit DATA_W-1.
  - HOLD→GAP.
  - GAP→IDLE.
- Sampling on the sck rising edge: in the clk cycle where sck is set to 1, shift_in <= {shift_in[DATA_W-2:0], miso}.
- Driving on the sck falling edge: in the cycle sck is set to 0 (HIGH→LOW), mosi is updated to the next bit. On the final falling edge, mosi holds its last value.
- Bit counter width is clog2(DATA_W)+1.
- rsp_valid pulses in the first GAP cycle, with rsp_data = final shift_in and rsp_id = latched id. rsp_data and rsp_id hold until the next pulse.
- There is no rsp back-pressure; consumers must take the pulse.
- Reset mid-transaction: on the next cycle, outputs return to reset values, no rsp_valid, and the pending word is dropped.

## Timing
- Handshake in cycle t with DIV=4, DATA_W=8:
  - ss falls at t+1.
  - First sck rise at t+5.
  - 8 rising edges at t+5+8k, for k=0..7.
  - Last sck fall at t+65; HOLD runs t+69..t+72.
  - ss rises and rsp_valid=1 at t+73.
  - IDLE at t+77; next handshake is possible at t+77.
- General period: 2·DIV + 2·DATA_W·DIV cycles from ss low to ss high, plus DIV cycles of GAP.
- Minimum ss-high time between transactions is DIV+1 cycles.
- Latency from handshake to rsp_valid is 1 + DIV·(2·DATA_W+2) cycles.

## Structure
- Package spi_pkg holds:
  - state enum (IDLE, SETUP, HIGH, LOW, HOLD, GAP);
  - CPOL=0 and CPHA=0 constants;
  - the clog2 helper function.
- Sub-module spi_rr_arbiter: two valid inputs plus last_grant in, grant index and ready vector out. This is purely combinational, while last_grant is registered in the parent.
- Top level holds the FSM, the DIV counter, the bit counter, and the two shift registers.

## Test plan
- Loopback (miso tied to mosi), DIV=4: req0 sends 0xA5 at t → exactly 8 sck rises, rsp_valid at t+73, rsp_data=0xA5, rsp_id=0.
- miso driven by a model returning 0x3C on sck rising edges while req1 sends 0xFF → rsp_data=0x3C, rsp_id=1, mosi is high at all 8 rising edges.
- req0 and req1 valid continuously from reset, sending 0x11 and 0x22 → grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; ss high ≥5 cycles between transactions.
- req1 asserted while a req0 transaction is active → req1_ready stays 0 until IDLE, then req1 is granted in the first IDLE cycle.
- rst pulsed at t+30 of a transaction → at t+31 ss=1, sck=0, mosi=0, busy=0; no rsp_valid; a new request completes normally afterwards.
- DIV=1, DATA_W=8, loopback 0x81 → sck period 2 clk cycles, rsp_valid at t+19, rsp_data=0x81.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master with round-robin front end.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_e;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin arbiter; the last-grant register lives in the parent.
module spi_rr_arbiter (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       idle_i,
    output logic       grant_o,
    output logic [1:0] ready_o
);

    always_comb begin
        grant_o = 1'b0;
        if (valid_i == 2'b11) begin
            grant_o = ~last_grant_i;
        end else if (valid_i[1]) begin
            grant_o = 1'b1;
        end
        // Ready follows the grant even with no valid; a handshake still needs valid.
        ready_o = {idle_i & grant_o, idle_i & ~grant_o};
    end

endmodule

// File: rtl/spi_master_arb.sv
// SPI mode-0 master: one DATA_W-bit word per transaction, two requesters arbitrated
// round-robin in IDLE, received word returned with the owning requester id.
module spi_master_arb
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              busy,
    output logic              sck,
    output logic              ss,
    output logic              mosi,
    input  logic              miso,
    output spi_state_e        state
);

    localparam int BCW = clog2(DATA_W) + 1;
    localparam int CW  = clog2(DIV) + 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(DIV - 1);
    localparam logic [BCW-1:0] BITS     = BCW'(DATA_W);

    spi_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              id_q;
    logic              last_grant_q;
    logic              sck_q;
    logic              ss_q;
    logic              mosi_q;
    logic              busy_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_id_q;

    logic              grant;
    logic [1:0]        ready;
    logic              accept;
    logic [DATA_W-1:0] sel_data;

    spi_rr_arbiter u_arb (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .idle_i       (state_q == IDLE),
        .grant_o      (grant),
        .ready_o      (ready)
    );

    assign accept   = (req0_valid & ready[0]) | (req1_valid & ready[1]);
    assign sel_data = grant ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            sck_q        <= CPOL;
            ss_q         <= 1'b1;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (accept) begin
                    state_q      <= SETUP;
                    cnt_q        <= CNT_LOAD;
                    bit_cnt_q    <= '0;
                    tx_q         <= sel_data;
                    id_q         <= grant;
                    last_grant_q <= grant;
                    ss_q         <= 1'b0;
                    sck_q        <= 1'b0;
                    mosi_q       <= sel_data[DATA_W-1];
                    busy_q       <= 1'b1;
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                cnt_q <= CNT_LOAD;
                unique case (state_q)
                    SETUP: begin
                        state_q   <= HIGH;
                        sck_q     <= 1'b1;
                        rx_q      <= {rx_q[DATA_W-2:0], miso};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    HIGH: begin
                        state_q <= LOW;
                        sck_q   <= 1'b0;
                        // After the last sample mosi keeps its final bit.
                        if (bit_cnt_q != BITS) begin
                            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                            mosi_q <= tx_q[DATA_W-2];
                        end
                    end
                    LOW: begin
                        if (bit_cnt_q == BITS) begin
                            state_q <= HOLD;
                        end else begin
                            state_q   <= HIGH;
                            sck_q     <= 1'b1;
                            rx_q      <= {rx_q[DATA_W-2:0], miso};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    HOLD: begin
                        state_q     <= GAP;
                        ss_q        <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rx_q;
                        rsp_id_q    <= id_q;
                    end
                    GAP: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ss_q    <= 1'b1;
                        sck_q   <= CPOL;
                    end
                endcase
            end
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = busy_q;
    assign sck        = sck_q;
    assign ss         = ss_q;
    assign mosi       = mosi_q;
    assign state      = state_q;

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: loopback / slave-model miso, arbitration, reset abort, DIV=1.
module tb_spi_master_arb;
    import spi_pkg::*;

    localparam int LAT = 1 + 4 * (2 * 8 + 2);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy, sck, ss, mosi, miso;
    logic [7:0] rsp_data;
    spi_state_e state;

    logic       b_req0_valid = 1'b0;
    logic [7:0] b_req0_data = '0;
    logic       b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_busy, b_sck, b_ss, b_mosi;
    logic [7:0] b_rsp_data;
    spi_state_e b_state;

    logic       loopback = 1'b1;
    logic       chk_mosi_high = 1'b0;
    logic [7:0] slave_word = 8'h3C;
    logic       model_bit = 1'b0;
    logic       m_last = 1'b1;
    logic [3:0] rsp_ids = '0;

    int cyc = 0, checks = 0, errors = 0;
    int rises = 0, ss_high = 0, hs_cnt = 0, rsp_cnt = 0;
    logic sck_prev = 1'b0, ss_prev = 1'b1;

    logic [8:0] exp_q[$];
    int         exp_t_q[$];

    assign miso = loopback ? mosi : model_bit;

    spi_master_arb #(.DATA_W(8), .DIV(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
        .sck(sck), .ss(ss), .mosi(mosi), .miso(miso), .state(state)
    );

    spi_master_arb #(.DATA_W(8), .DIV(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
        .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(b_req1_ready),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_id(b_rsp_id), .busy(b_busy),
        .sck(b_sck), .ss(b_ss), .mosi(b_mosi), .miso(b_mosi), .state(b_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor and scoreboard, sampling 2 ns after the falling edge.
    always @(negedge clk) begin
        logic exp_id, obs_id;
        logic [8:0] e;
        #2;
        if (rst) begin
            rises = 0;
            ss_high = 0;
            m_last = 1'b1;
            exp_q.delete();
            exp_t_q.delete();
        end else begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                exp_id = (req0_valid && req1_valid) ? ~m_last : req1_valid;
                obs_id = req1_valid && req1_ready;
                chk("grant_id", obs_id, exp_id);
                m_last = exp_id;
                hs_cnt++;
                exp_q.push_back({exp_id, loopback ? (exp_id ? req1_data : req0_data) : slave_word});
                exp_t_q.push_back(cyc + LAT);
            end
            if (sck && !sck_prev) begin
                rises++;
                if (chk_mosi_high) chk("mosi_at_rise", mosi, 1'b1);
            end
            if (!ss && ss_prev) begin
                if (hs_cnt > 1) chk("ss_high_min", ss_high >= 5, 1'b1);
                rises = 0;
            end
            if (ss && !ss_prev) begin
                chk("sck_rises", rises, 8);
                ss_high = 0;
            end
            if (ss) ss_high++;
            model_bit = (rises < 8) ? slave_word[7 - rises] : 1'b0;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_ids = {rsp_ids[2:0], rsp_id};
                chk("rsp_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e[7:0]);
                    chk("rsp_id", rsp_id, e[8]);
                    chk("rsp_latency", cyc, exp_t_q.pop_front());
                end
            end
        end
        sck_prev = sck;
        ss_prev = ss;
    end

    task automatic send(input logic id, input logic [7:0] d, output int t);
        int n;
        n = 0;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 300) begin
            @(negedge clk); #1; n++;
        end
        chk("send_accept", n < 300, 1'b1);
        t = cyc;
        @(negedge clk);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk); #3; n++;
        end
        chk("drain", n < 400, 1'b1);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int t, n, base, snap, fr, sr, brc;
        logic [7:0] bd;
        logic bid, bprev;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_sck", sck, 0);
        chk("rst_ss", ss, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state, IDLE);
        @(negedge clk);
        rst = 1'b0;

        // Loopback 0xA5 from requester 0.
        loopback = 1'b1;
        send(1'b0, 8'hA5, t);
        #1;
        chk("busy_after_accept", busy, 1);
        chk("ss_low_t1", ss, 0);
        drain();

        // Slave model returns 0x3C while requester 1 sends 0xFF.
        loopback = 1'b0;
        slave_word = 8'h3C;
        chk_mosi_high = 1'b1;
        send(1'b1, 8'hFF, t);
        drain();
        chk_mosi_high = 1'b0;

        // Both requesters valid continuously: grants alternate.
        loopback = 1'b1;
        base = hs_cnt;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        n = 0;
        while (hs_cnt < base + 4 && n < 1000) begin @(negedge clk); n++; end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_four_grants", hs_cnt - base, 4);
        drain();
        chk("rr_id_sequence", rsp_ids, 4'b0101);

        // req1 arrives mid-transaction: held off until IDLE, then granted at once.
        send(1'b0, 8'h5A, t);
        repeat (9) @(negedge clk);
        req1_valid = 1'b1; req1_data = 8'hC3;
        n = 0;
        #1;
        while (state != IDLE && n < 200) begin
            chk("req1_blocked", req1_ready, 0);
            @(negedge clk); #1; n++;
        end
        chk("req1_ready_idle", req1_ready, 1);
        chk("req1_grant_cycle", cyc, t + 77);
        @(negedge clk);
        req1_valid = 1'b0;
        drain();

        // Reset at t+30 aborts the transaction.
        send(1'b0, 8'h96, t);
        n = 0;
        while (cyc < t + 30 && n < 100) begin @(negedge clk); n++; end
        rst = 1'b1;
        snap = rsp_cnt;
        @(negedge clk);
        #1;
        chk("abort_ss", ss, 1);
        chk("abort_sck", sck, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_busy", busy, 0);
        chk("abort_state", state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_no_rsp", rsp_cnt, snap);
        send(1'b1, 8'h3C, t);
        drain();
        chk("after_abort_rsp", rsp_cnt, snap + 1);

        // DIV=1 loopback of 0x81.
        @(negedge clk);
        b_req0_valid = 1'b1; b_req0_data = 8'h81;
        #1;
        chk("b_ready", b_req0_ready, 1);
        t = cyc;
        @(negedge clk);
        b_req0_valid = 1'b0;
        fr = -1; sr = -1; brc = -1; bd = '0; bid = 1'b1; bprev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (b_sck && !bprev) begin
                if (fr < 0) fr = cyc;
                else if (sr < 0) sr = cyc;
            end
            bprev = b_sck;
            if (b_rsp_valid && brc < 0) begin
                brc = cyc; bd = b_rsp_data; bid = b_rsp_id;
            end
            @(negedge clk);
        end
        chk("b_sck_period", sr - fr, 2);
        chk("b_rsp_cycle", brc, t + 19);
        chk("b_rsp_data", bd, 8'h81);
        chk("b_rsp_id", bid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
